sdp_fifo_ctrl: RTL and testbench

//   FIFO controller that sequences an external simple dual-port RAM (ram_sdp_one_clock) as

---
 rtl/sdp_fifo_ctrl.sv | 110 +++++++++++
 tb/tb_sdp_fifo_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdp_fifo_ctrl.sv
// FIFO controller around an external 1-clock simple dual-port RAM.
// Adds valid/ready push and FWFT pop ports, with a 2-entry prefetch buffer that hides read latency.
module sdp_fifo_ctrl #(
  parameter  int unsigned DWIDTH = 64,
  parameter  int unsigned DEPTH  = 32,
  localparam int unsigned AWIDTH = $clog2(DEPTH),
  localparam int unsigned CWIDTH = $clog2(DEPTH + 3)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic [CWIDTH-1:0] count,
  output logic              ram_ena,
  output logic              ram_wea,
  output logic [AWIDTH-1:0] ram_addra,
  output logic [DWIDTH-1:0] ram_dia,
  output logic              ram_enb,
  output logic [AWIDTH-1:0] ram_addrb,
  input  logic [DWIDTH-1:0] ram_dob
);

  localparam int unsigned PWIDTH = AWIDTH + 1;

  logic [PWIDTH-1:0] wr_ptr;
  logic [PWIDTH-1:0] rd_ptr;
  logic [PWIDTH-1:0] ram_cnt;
  logic              rd_inflight;
  logic [1:0]        buf_cnt;
  logic [DWIDTH-1:0] pf0;
  logic [DWIDTH-1:0] pf1;

  logic              push;
  logic              pop;
  logic              rd_issue;
  logic [1:0]        occ;
  logic [1:0]        slot;
  logic [1:0]        buf_cnt_n;
  logic [DWIDTH-1:0] pf0_n;
  logic [DWIDTH-1:0] pf1_n;

  assign ram_cnt = wr_ptr - rd_ptr;

  // Handshake and prefetch decisions; read eligibility looks at registered fill only
  always_comb begin
    in_ready  = (ram_cnt < PWIDTH'(DEPTH));
    out_valid = (buf_cnt != 2'd0);
    out_data  = pf0;
    push      = in_valid & in_ready & ~rst;
    pop       = out_valid & out_ready & ~rst;
    occ       = buf_cnt + 2'(rd_inflight);
    rd_issue  = (ram_cnt != '0) & ~rst & (occ < (2'd2 + 2'(pop)));
    slot      = buf_cnt - 2'(pop);
    buf_cnt_n = buf_cnt - 2'(pop) + 2'(rd_inflight);
  end

  assign ram_ena   = push;
  assign ram_wea   = push;
  assign ram_addra = wr_ptr[AWIDTH-1:0];
  assign ram_dia   = in_data;
  assign ram_enb   = rd_issue;
  assign ram_addrb = rd_ptr[AWIDTH-1:0];

  // Buffer next state: shift on pop, then land returning RAM data in the first free slot
  always_comb begin
    pf0_n = pf0;
    pf1_n = pf1;
    if (pop) begin
      pf0_n = pf1;
    end
    if (rd_inflight) begin
      if (slot == 2'd0) begin
        pf0_n = ram_dob;
      end else begin
        pf1_n = ram_dob;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rd_inflight <= 1'b0;
      buf_cnt     <= 2'd0;
      count       <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PWIDTH'(1);
      end
      if (rd_issue) begin
        rd_ptr <= rd_ptr + PWIDTH'(1);
      end
      rd_inflight <= rd_issue;
      buf_cnt     <= buf_cnt_n;
      count       <= count + CWIDTH'(push) - CWIDTH'(pop);
    end
  end

  // Data-only registers; contents are qualified by buf_cnt
  always_ff @(posedge clk) begin
    pf0 <= pf0_n;
    pf1 <= pf1_n;
  end

endmodule

// File: tb/tb_sdp_fifo_ctrl.sv
// Self-checking bench for sdp_fifo_ctrl: queue-level reference model compared every cycle,
// plus directed literal checks for fill, latency, throughput, reset and full-rate operation.
module tb_sdp_fifo_ctrl;
  localparam int unsigned DWIDTH = 64;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned AWIDTH = $clog2(DEPTH);
  localparam int unsigned CWIDTH = $clog2(DEPTH + 3);

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DWIDTH-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] out_data;
  logic [CWIDTH-1:0] count;
  logic              ram_ena;
  logic              ram_wea;
  logic [AWIDTH-1:0] ram_addra;
  logic [DWIDTH-1:0] ram_dia;
  logic              ram_enb;
  logic [AWIDTH-1:0] ram_addrb;
  logic [DWIDTH-1:0] ram_dob;

  sdp_fifo_ctrl #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count),
    .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dia(ram_dia),
    .ram_enb(ram_enb), .ram_addrb(ram_addrb), .ram_dob(ram_dob)
  );

  always #5 clk = ~clk;

  // External RAM: one clock, read data the cycle after enable
  logic [DWIDTH-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_ena && ram_wea) mem[ram_addra] <= ram_dia;
    if (ram_enb) ram_dob <= mem[ram_addrb];
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: words sitting in RAM, one word in flight, words in the output buffer
  logic [DWIDTH-1:0] m_ram[$];
  logic [DWIDTH-1:0] m_buf[$];
  logic [DWIDTH-1:0] m_infl_data;
  logic [DWIDTH-1:0] pop_log[$];
  logic [DWIDTH-1:0] p_data;
  bit m_infl = 0;
  bit armed  = 0;
  bit p_hold = 0;
  bit exp_ir, exp_ov, exp_push, exp_pop, exp_rd;
  int m_wcnt = 0;
  int m_rcnt = 0;

  always @(negedge clk) begin
    if (armed) begin
      exp_ir   = m_ram.size() < DEPTH;
      exp_ov   = m_buf.size() > 0;
      exp_push = in_valid && exp_ir && !rst;
      exp_pop  = exp_ov && out_ready && !rst;
      exp_rd   = !rst && (m_ram.size() > 0) &&
                 ((m_buf.size() + int'(m_infl) - int'(exp_pop)) < 2);
      check("in_ready", 64'(in_ready), 64'(exp_ir));
      check("out_valid", 64'(out_valid), 64'(exp_ov));
      check("count", 64'(count), 64'(m_ram.size() + int'(m_infl) + m_buf.size()));
      check("count_max", 64'(count <= CWIDTH'(DEPTH + 2)), 64'd1);
      if (exp_ov) check("out_data", out_data, m_buf[0]);
      check("ram_ena", 64'(ram_ena), 64'(exp_push));
      check("ram_wea", 64'(ram_wea), 64'(exp_push));
      if (exp_push) begin
        check("ram_addra", 64'(ram_addra), 64'(m_wcnt % DEPTH));
        check("ram_dia", ram_dia, in_data);
      end
      check("ram_enb", 64'(ram_enb), 64'(exp_rd));
      if (exp_rd) check("ram_addrb", 64'(ram_addrb), 64'(m_rcnt % DEPTH));
      if (ram_ena && ram_enb) check("port_collision", 64'(ram_addra == ram_addrb), 64'd0);
      if (p_hold) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", out_data, p_data);
      end
      p_hold = out_valid && !out_ready && !rst;
      p_data = out_data;
      if (out_valid && out_ready && !rst) pop_log.push_back(out_data);
    end
    if (rst) begin
      m_ram.delete();
      m_buf.delete();
      m_infl = 0;
      m_wcnt = 0;
      m_rcnt = 0;
      p_hold = 0;
    end else if (armed) begin
      if (exp_pop) void'(m_buf.pop_front());
      if (m_infl) m_buf.push_back(m_infl_data);
      m_infl = exp_rd;
      if (exp_rd) begin
        m_infl_data = m_ram.pop_front();
        m_rcnt++;
      end
      if (exp_push) begin
        m_ram.push_back(in_data);
        m_wcnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Apply inputs for one cycle; report whether a push and a pop happened at that edge
  task automatic drive(input bit v, input bit r, input logic [63:0] d, output bit acc, output bit pp);
    in_valid  = v;
    out_ready = r;
    in_data   = d;
    acc = v && in_ready;
    pp  = r && out_valid;
    step();
  endtask

  task automatic drain();
    bit a, p;
    for (int i = 0; i < 200 && count != '0; i++) drive(0, 1, 64'd0, a, p);
    out_ready = 0;
    check("drain_empty", 64'(count), 64'd0);
  endtask

  initial begin
    bit a, p;
    int d, c, first, last;
    bit seen0, seen1;
    rst = 1; in_valid = 0; out_ready = 0; in_data = '0;
    step();
    armed = 1;
    step();
    rst = 0;
    check("rst_count", 64'(count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_ram_ena", 64'(ram_ena), 64'd0);
    check("rst_ram_enb", 64'(ram_enb), 64'd0);

    // 1: fill with no pops, capacity is DEPTH+2
    d = 0;
    for (int i = 0; i < 50; i++) begin
      drive(d <= 40, 0, 64'(d), a, p);
      if (a) d++;
    end
    drive(0, 0, 64'd0, a, p);
    check("t1_accepted", 64'(d), 64'd34);
    check("t1_in_ready", 64'(in_ready), 64'd0);
    check("t1_count", 64'(count), 64'd34);
    pop_log.delete();
    drain();
    check("t1_pop_count", 64'(pop_log.size()), 64'd34);
    for (int i = 0; i < pop_log.size(); i++) check("t1_order", pop_log[i], 64'(i));

    // 2: single-word latency
    drive(1, 0, 64'hA5, a, p);
    check("t2_n0_count", 64'(count), 64'd1);
    check("t2_n0_valid", 64'(out_valid), 64'd0);
    drive(0, 0, 64'd0, a, p);
    check("t2_n1_count", 64'(count), 64'd1);
    check("t2_n1_valid", 64'(out_valid), 64'd0);
    drive(0, 0, 64'd0, a, p);
    check("t2_n2_count", 64'(count), 64'd1);
    check("t2_n2_valid", 64'(out_valid), 64'd1);
    check("t2_n2_data", out_data, 64'hA5);
    drive(0, 1, 64'd0, a, p);
    check("t2_n3_count", 64'(count), 64'd0);
    check("t2_n3_valid", 64'(out_valid), 64'd0);
    out_ready = 0;

    // 3: streaming push+pop, no bubbles after the first word
    pop_log.delete();
    d = 0; c = 0; first = -1; last = -1;
    while (pop_log.size() < 200 && c < 400) begin
      drive(d < 200, 1, 64'(d), a, p);
      if (a) d++;
      if (p) begin
        if (first < 0) first = c;
        last = c;
      end
      c++;
    end
    check("t3_pop_count", 64'(pop_log.size()), 64'd200);
    check("t3_first_pop_cycle", 64'(first), 64'd3);
    check("t3_no_bubbles", 64'(last - first), 64'd199);
    for (int i = 0; i < pop_log.size(); i++) check("t3_order", pop_log[i], 64'(i));
    drain();

    // 4: random valid/ready, random data
    pop_log.delete();
    d = 0; c = 0;
    while (d < 10000 && c < 60000) begin
      drive((d < 10000) && ($urandom_range(0, 1) == 1), $urandom_range(0, 1) == 1,
            {$urandom, $urandom}, a, p);
      if (a) d++;
      c++;
    end
    check("t4_accepted", 64'(d), 64'd10000);
    drain();
    check("t4_popped", 64'(pop_log.size()), 64'd10000);

    // 5: reset with a read in flight drops everything
    d = 0; c = 0;
    while (d < 20 && c < 40) begin
      drive(1, 0, 64'(100 + d), a, p);
      if (a) d++;
      c++;
    end
    for (int i = 0; i < 3; i++) drive(0, 0, 64'd0, a, p);
    in_valid = 0;
    out_ready = 1;
    #1;
    check("t5_read_issued", 64'(ram_enb), 64'd1);
    step();
    rst = 1;
    drive(0, 0, 64'd0, a, p);
    rst = 0;
    check("t5_out_valid", 64'(out_valid), 64'd0);
    check("t5_count", 64'(count), 64'd0);
    check("t5_in_ready", 64'(in_ready), 64'd1);
    pop_log.delete();
    drive(1, 0, 64'h7, a, p);
    drive(0, 0, 64'd0, a, p);
    drain();
    check("t5_pop_count", 64'(pop_log.size()), 64'd1);
    if (pop_log.size() > 0) check("t5_first_word", pop_log[0], 64'h7);

    // 6: full, then push and pop every cycle
    pop_log.delete();
    d = 0; c = 0;
    while (in_ready && c < 60) begin
      drive(1, 0, 64'(d), a, p);
      if (a) d++;
      c++;
    end
    drive(0, 0, 64'd0, a, p);
    check("t6_full_count", 64'(count), 64'd34);
    seen0 = 0; seen1 = 0;
    for (int i = 0; i < 100; i++) begin
      if (in_ready) seen1 = 1; else seen0 = 1;
      drive(1, 1, 64'(d), a, p);
      if (a) d++;
    end
    check("t6_in_ready_low", 64'(seen0), 64'd1);
    check("t6_in_ready_high", 64'(seen1), 64'd1);
    drain();
    check("t6_pop_count", 64'(pop_log.size()), 64'(d));
    for (int i = 0; i < pop_log.size(); i++) check("t6_order", pop_log[i], 64'(i));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
